aes_round_pipe_stage: RTL and testbench
=======================================

// Module: aes_round_pipe_stage
// PURPOSE
//  Parametrised, elastic AES-128 encryption round stage for the visc AES accelerator. Executes ROUNDS consecutive
//  AES rounds, one register stage per round, with valid/ready backpressure, per-block tag and round-key bundle.
//  Stages chain back-to-back (keys/tag forwarded) to build a full 10-round engine split across any number of stages.
// PARAMETERS
//  ROUNDS       2    rounds executed in this stage (1..10); also the latency in cycles
//  FIRST_ROUND  1    AES round index of the first round here (1..10); FIRST_ROUND+ROUNDS-1 <= 10
//  NUM_KEYS     11   round keys carried in the bundle (key k at in_keys[128*k +: 128])
//  TAG_W        8    width of the opaque per-block tag
// PORTS
//  clk        in   1              clock
//  rst_n      in   1              asynchronous active-low reset
//  flush      in   1              synchronous: drop all in-flight blocks
//  in_valid   in   1              input block valid
//  in_ready   out  1              stage accepts a block this cycle
//  in_data    in   128            AES state (plaintext when FIRST_ROUND==1)
//  in_keys    in   128*NUM_KEYS   expanded round-key bundle for this block
//  in_tag     in   TAG_W          opaque tag
//  out_valid  out  1              output block valid
//  out_ready  in   1              downstream accepts
//  out_data   out  128            state after round FIRST_ROUND+ROUNDS-1
//  out_keys   out  128*NUM_KEYS   key bundle travelling with the block, unchanged
//  out_tag    out  TAG_W          tag travelling with the block
//  busy       out  1              any pipeline slot valid
// BEHAVIOUR
//  - Reset: rst_n is asynchronous, active-low; clock is clk. All slot valid bits, data, keys and tags clear to 0,
//    so out_valid=0, out_data=0, out_keys=0, out_tag=0, busy=0 and in_ready=1 (out_valid=0).
//  - Pipeline: slot[i] holds the state after round FIRST_ROUND+i. Stall = out_valid & ~out_ready. All slots advance
//    together when not stalled. Accept = in_valid & in_ready. Latency = ROUNDS cycles. Throughput = 1 block/cycle.
//  - in_ready = ~stall & ~flush (combinational). No combinational path from in_valid to out_valid.
//  - Round r: SubBytes, ShiftRows, MixColumns, then XOR with key[r]. MixColumns is omitted when r==10.
//  - When FIRST_ROUND==1, the initial AddRoundKey (in_data ^ key[0]) is applied before round 1.
//  - Keys and tag ride in each slot with their block. Keys for round r are taken from that block's own bundle,
//    never from the live input.
//  - Bubbles (valid=0) propagate; data in an invalid slot is don't-care. Slots still advance during out_ready=0
//    when the last slot is empty (bubble collapse is not required).
//  - flush: clears every valid bit next edge and wins over a simultaneous accept; the input is not taken.
//  - Reset mid-operation drops all blocks; no partial output is produced.
//  - out_* are held stable while out_valid & ~out_ready.
// CONFIGURATION
//  `AES_STAGE_PERF_CNT_EN defined:
//    - adds ports perf_blk_cnt (out, 32): count of blocks that left (out_valid & out_ready).
//    - adds ports perf_stall_cnt (out, 32): count of stall cycles.
//    - both counters wrap modulo 2^32, reset to 0, and are cleared by flush.
//  Undefined: those ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  - Package aes_pkg holds:
//    - AES_NR=10 and the aes_state_t (128-bit) and aes_key_t typedefs;
//    - sbox(), xtime(), shift_rows(), mix_columns() functions;
//    - stage slot struct {valid, data, keys, tag}.
//  - Sub-module aes_round_comb (combinational: state, key, last -> next state) is instantiated ROUNDS times in a
//    generate loop. Elaboration-time $error when FIRST_ROUND+ROUNDS-1 > 10 or FIRST_ROUND+ROUNDS-1 >= NUM_KEYS.
// TESTING  (FIPS-197 App. C.1)
//  Vector: key = 000102030405060708090a0b0c0d0e0f, pt = 00112233445566778899aabbccddeeff.
//  1. ROUNDS=10, FIRST_ROUND=1, single block -> out_valid exactly 10 cycles after accept,
//     out_data = 69c4e0d86a7b0430d8cdb78070b4c55a, out_tag and out_keys equal the inputs.
//  2. ROUNDS=2, FIRST_ROUND=1 chained to ROUNDS=8, FIRST_ROUND=3 -> second stage emits 69c4e0d8... after 10 cycles;
//     first stage out_data = 4915598f55e5d7a0daca94fa1f0a63f7.
//  3. 16 back-to-back blocks (tags 0..15), out_ready=1 -> 16 consecutive out_valid cycles, tags in order, in_ready
//     never drops.
//  4. Stream with out_ready held 0 for 5 cycles while full -> in_ready=0 in those cycles, out_* stable,
//     no loss or duplication, order preserved.
//  5. flush with in_valid=1 and 2 blocks in flight -> block not accepted; out_valid=0 and busy=0 next cycle;
//     later blocks are correct.
//  6. rst_n asserted mid-stream, then perf build -> all outputs 0 immediately; perf_blk_cnt=3 after 3 handshakes;
//     perf_stall_cnt counts stall cycles.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 types, constants and round helper functions
// for the visc AES accelerator round stages.
//   AES_NR        number of AES-128 rounds
//   aes_state_t   128-bit AES state, byte 0 in bits [127:120], column-major
//   aes_key_t     128-bit round key, same byte order as the state
//   aes_slot_t    pipeline slot {valid, data, keys, tag} for the standard
//                 11-key bundle and 8-bit tag
//   xtime, gf_mul, sbox, shift_rows, mix_columns
package aes_pkg;

    localparam int unsigned AES_NR        = 10;
    localparam int unsigned AES_STD_KEYS  = AES_NR + 1;
    localparam int unsigned AES_STD_TAG_W = 8;

    typedef logic [127:0] aes_state_t;
    typedef logic [127:0] aes_key_t;

    typedef struct packed {
        logic                           valid;
        aes_state_t                     data;
        aes_key_t [AES_STD_KEYS-1:0]    keys;
        logic [AES_STD_TAG_W-1:0]       tag;
    } aes_slot_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128), then the
    // affine transform; maps 0 to 0x63 because 0^254 = 0.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int unsigned i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic aes_state_t shift_rows(input aes_state_t s);
        aes_state_t t;
        t = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                t[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
        return t;
    endfunction

    function automatic aes_state_t mix_columns(input aes_state_t s);
        aes_state_t t;
        logic [7:0] a0, a1, a2, a3;
        t = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            t[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            t[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            t[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            t[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return t;
    endfunction

endpackage

// File: rtl/aes_round_comb.sv
// aes_round_comb: one combinational AES-128 encryption round.
//   i_state  state entering the round
//   i_key    round key for this round
//   i_last   final round: MixColumns is skipped
//   o_state  SubBytes -> ShiftRows -> MixColumns (unless last) -> AddRoundKey
module aes_round_comb
    import aes_pkg::*;
(
    input  logic [127:0] i_state,
    input  logic [127:0] i_key,
    input  logic         i_last,
    output logic [127:0] o_state
);

    logic [127:0] w_sub;
    logic [127:0] w_shift;

    always_comb begin
        w_sub = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            w_sub[8*i +: 8] = sbox(i_state[8*i +: 8]);
        end
    end

    assign w_shift = shift_rows(w_sub);
    assign o_state = (i_last ? w_shift : mix_columns(w_shift)) ^ i_key;

endmodule

// File: rtl/aes_round_pipe_stage.sv
// aes_round_pipe_stage: elastic AES-128 encryption stage running ROUNDS
// consecutive rounds starting at round FIRST_ROUND, one register slot per
// round. Key bundle and tag travel with each block so stages can be chained.
//   clk, rst_n         clock, asynchronous active-low reset
//   flush              synchronous drop of all in-flight blocks
//   in_valid/in_ready  input handshake; in_data, in_keys, in_tag
//   out_valid/out_ready output handshake; out_data, out_keys, out_tag
//   busy               any slot holds a valid block
// Optional build macro AES_STAGE_PERF_CNT_EN adds perf_blk_cnt (blocks
// delivered) and perf_stall_cnt (stall cycles), both cleared by flush.
module aes_round_pipe_stage
    import aes_pkg::*;
#(
    parameter int unsigned ROUNDS      = 2,
    parameter int unsigned FIRST_ROUND = 1,
    parameter int unsigned NUM_KEYS    = 11,
    parameter int unsigned TAG_W       = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [127:0]            in_data,
    input  logic [128*NUM_KEYS-1:0] in_keys,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [127:0]            out_data,
    output logic [128*NUM_KEYS-1:0] out_keys,
    output logic [TAG_W-1:0]        out_tag,
    output logic                    busy
`ifdef AES_STAGE_PERF_CNT_EN
    ,
    output logic [31:0]             perf_blk_cnt,
    output logic [31:0]             perf_stall_cnt
`endif
);

    localparam int unsigned LAST_ROUND = FIRST_ROUND + ROUNDS - 1;

    if (ROUNDS < 1 || FIRST_ROUND < 1 || LAST_ROUND > AES_NR || LAST_ROUND >= NUM_KEYS) begin : g_cfg_err
        $error("aes_round_pipe_stage: rounds %0d..%0d not executable with %0d keys",
               FIRST_ROUND, LAST_ROUND, NUM_KEYS);
    end

    // Same layout as aes_slot_t, sized by this instance's bundle and tag.
    typedef struct packed {
        logic                    valid;
        logic [127:0]            data;
        logic [128*NUM_KEYS-1:0] keys;
        logic [TAG_W-1:0]        tag;
    } slot_t;

    slot_t        r_slot [ROUNDS];
    logic [127:0] w_round_out [ROUNDS];
    logic [127:0] w_stage_in;
    logic         w_stall;
    logic         w_accept;

    assign w_stall  = r_slot[ROUNDS-1].valid & ~out_ready;
    assign in_ready = ~w_stall & ~flush;
    assign w_accept = in_valid & in_ready;

    // The initial AddRoundKey folds into the input of the first round.
    if (FIRST_ROUND == 1) begin : g_ark
        assign w_stage_in = in_data ^ in_keys[127:0];
    end else begin : g_no_ark
        assign w_stage_in = in_data;
    end

    // Round for slot g reads the block in front of it, including its own keys.
    for (genvar g = 0; g < ROUNDS; g++) begin : g_round
        localparam int unsigned R = FIRST_ROUND + g;
        logic [127:0] w_src_state;
        logic [127:0] w_key;
        if (g == 0) begin : g_head
            assign w_src_state = w_stage_in;
            assign w_key       = in_keys[128*R +: 128];
        end else begin : g_tail
            assign w_src_state = r_slot[g-1].data;
            assign w_key       = r_slot[g-1].keys[128*R +: 128];
        end
        aes_round_comb u_round (
            .i_state (w_src_state),
            .i_key   (w_key),
            .i_last  (R == AES_NR),
            .o_state (w_round_out[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ROUNDS; i++) begin
                r_slot[i] <= '0;
            end
        end else if (flush) begin
            for (int unsigned i = 0; i < ROUNDS; i++) begin
                r_slot[i].valid <= 1'b0;
            end
        end else if (!w_stall) begin
            r_slot[0] <= '{valid: w_accept, data: w_round_out[0], keys: in_keys, tag: in_tag};
            for (int unsigned i = 1; i < ROUNDS; i++) begin
                r_slot[i] <= '{valid: r_slot[i-1].valid, data: w_round_out[i],
                               keys: r_slot[i-1].keys, tag: r_slot[i-1].tag};
            end
        end
    end

    assign out_valid = r_slot[ROUNDS-1].valid;
    assign out_data  = r_slot[ROUNDS-1].data;
    assign out_keys  = r_slot[ROUNDS-1].keys;
    assign out_tag   = r_slot[ROUNDS-1].tag;

    always_comb begin
        busy = 1'b0;
        for (int unsigned i = 0; i < ROUNDS; i++) begin
            busy = busy | r_slot[i].valid;
        end
    end

`ifdef AES_STAGE_PERF_CNT_EN
    logic [31:0] r_blk_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blk_cnt   <= '0;
            r_stall_cnt <= '0;
        end else if (flush) begin
            r_blk_cnt   <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (out_valid & out_ready) r_blk_cnt <= r_blk_cnt + 32'd1;
            if (w_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign perf_blk_cnt   = r_blk_cnt;
    assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_aes_round_pipe_stage.sv
// Bench: a 2-round stage (rounds 1..2) chained into an 8-round stage
// (rounds 3..10), checked against a byte-array AES reference model with
// a per-stage scoreboard. Build with AES_STAGE_PERF_CNT_EN to also check
// the perf counters.
module tb_aes_round_pipe_stage;

    localparam int unsigned NK = 11;
    localparam int unsigned TW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n, flush, in_valid, out_ready;
    logic [127:0]        in_data;
    logic [128*NK-1:0]   in_keys;
    logic [TW-1:0]       in_tag;

    logic                a_in_ready, a_out_valid, a_busy;
    logic [127:0]        a_out_data;
    logic [128*NK-1:0]   a_out_keys;
    logic [TW-1:0]       a_out_tag;
    logic                b_in_ready, b_out_valid, b_busy;
    logic [127:0]        b_out_data;
    logic [128*NK-1:0]   b_out_keys;
    logic [TW-1:0]       b_out_tag;
`ifdef AES_STAGE_PERF_CNT_EN
    logic [31:0]         a_blk, a_stall, b_blk, b_stall;
`endif

    aes_round_pipe_stage #(.ROUNDS(2), .FIRST_ROUND(1), .NUM_KEYS(NK), .TAG_W(TW)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .in_keys(in_keys), .in_tag(in_tag),
        .out_valid(a_out_valid), .out_ready(b_in_ready),
        .out_data(a_out_data), .out_keys(a_out_keys), .out_tag(a_out_tag),
        .busy(a_busy)
`ifdef AES_STAGE_PERF_CNT_EN
        , .perf_blk_cnt(a_blk), .perf_stall_cnt(a_stall)
`endif
    );

    aes_round_pipe_stage #(.ROUNDS(8), .FIRST_ROUND(3), .NUM_KEYS(NK), .TAG_W(TW)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(a_out_valid), .in_ready(b_in_ready),
        .in_data(a_out_data), .in_keys(a_out_keys), .in_tag(a_out_tag),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_data(b_out_data), .out_keys(b_out_keys), .out_tag(b_out_tag),
        .busy(b_busy)
`ifdef AES_STAGE_PERF_CNT_EN
        , .perf_blk_cnt(b_blk), .perf_stall_cnt(b_stall)
`endif
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] sb [256];

    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return r;
    endfunction

    function automatic logic [7:0] coef(input int i, input int j);
        case ((j + 4 - i) % 4)
            0: return 8'h02;
            1: return 8'h03;
            default: return 8'h01;
        endcase
    endfunction

    function automatic logic [127:0] model_rounds(input logic [127:0] din, input logic [128*NK-1:0] k,
                                                  input int first, input int n);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   v;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = din[127 - 8*i -: 8];
        if (first == 1)
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127 - 8*i -: 8];
        for (int r = first; r < first + n; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++) t[4*c + w] = s[4*((c + w) % 4) + w];
            for (int c = 0; c < 4; c++)
                for (int i = 0; i < 4; i++) begin
                    if (r == 10) v = t[4*c + i];
                    else begin
                        v = 8'h00;
                        for (int j = 0; j < 4; j++) v = v ^ mul(coef(i, j), t[4*c + j]);
                    end
                    s[4*c + i] = v ^ k[128*r + 127 - 8*(4*c + i) -: 8];
                end
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [128*NK-1:0] expand(input logic [127:0] key);
        logic [31:0]       w [44];
        logic [31:0]       t;
        logic [7:0]        rc;
        logic [128*NK-1:0] b;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
                t[31:24] = t[31:24] ^ rc;
                rc = mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int k = 0; k < 11; k++)
            for (int j = 0; j < 4; j++) b[128*k + 127 - 32*j -: 32] = w[4*k + j];
        return b;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [128*NK-1:0] rand_keys();
        logic [128*NK-1:0] b;
        for (int i = 0; i < 4*NK; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [127:0]      din;
        logic [128*NK-1:0] keys;
        logic [TW-1:0]     tag;
    } blk_t;

    blk_t qa [$];
    blk_t qb [$];

    logic              d_valid = 1'b0, d_flush = 1'b0, d_oready = 1'b1;
    logic [127:0]      d_data = '0;
    logic [128*NK-1:0] d_keys = '0;
    logic [TW-1:0]     d_tag = '0;

    logic              hold_a = 1'b0, hold_b = 1'b0;
    logic [127:0]      prev_a_data, prev_b_data;
    logic [TW-1:0]     prev_a_tag, prev_b_tag;
    int                m_a_blk = 0, m_a_stall = 0, m_b_blk = 0, m_b_stall = 0;

    // One clock: drive at negedge, check settled outputs, account for the
    // transfers that the following posedge will perform.
    task automatic tick();
        blk_t e;
        @(negedge clk);
        in_valid  = d_valid;
        in_data   = d_data;
        in_keys   = d_keys;
        in_tag    = d_tag;
        flush     = d_flush;
        out_ready = d_oready;
        #1;
        cyc++;
        check("a_in_ready", a_in_ready, !(a_out_valid && !b_in_ready) && !flush);
        check("b_in_ready", b_in_ready, !(b_out_valid && !out_ready) && !flush);
        check("a_busy", a_busy, qa.size() != 0);
        check("b_busy", b_busy, qb.size() != 0);
        if (hold_a) begin
            check("a_hold_valid", a_out_valid, 1'b1);
            check("a_hold_data", a_out_data, prev_a_data);
            check("a_hold_tag", a_out_tag, prev_a_tag);
        end
        if (hold_b) begin
            check("b_hold_valid", b_out_valid, 1'b1);
            check("b_hold_data", b_out_data, prev_b_data);
            check("b_hold_tag", b_out_tag, prev_b_tag);
        end
`ifdef AES_STAGE_PERF_CNT_EN
        check("a_perf_blk", a_blk, m_a_blk);
        check("a_perf_stall", a_stall, m_a_stall);
        check("b_perf_blk", b_blk, m_b_blk);
        check("b_perf_stall", b_stall, m_b_stall);
`endif
        if (b_out_valid && out_ready) begin
            check("b_out_expected", qb.size() != 0, 1'b1);
            if (qb.size() != 0) begin
                e = qb.pop_front();
                check("b_data", b_out_data, model_rounds(e.din, e.keys, 1, 10));
                check("b_tag", b_out_tag, e.tag);
                check("b_keys", b_out_keys == e.keys, 1'b1);
            end
            m_b_blk++;
        end
        if (b_out_valid && !out_ready) m_b_stall++;
        if (a_out_valid && b_in_ready) begin
            check("a_out_expected", qa.size() != 0, 1'b1);
            if (qa.size() != 0) begin
                e = qa.pop_front();
                check("a_data", a_out_data, model_rounds(e.din, e.keys, 1, 2));
                check("a_tag", a_out_tag, e.tag);
                check("a_keys", a_out_keys == e.keys, 1'b1);
                qb.push_back(e);
            end
            m_a_blk++;
        end
        if (a_out_valid && !b_in_ready) m_a_stall++;
        if (in_valid && a_in_ready) qa.push_back('{in_data, in_keys, in_tag});
        if (flush) begin
            qa.delete();
            qb.delete();
            m_a_blk = 0; m_a_stall = 0; m_b_blk = 0; m_b_stall = 0;
        end
        hold_a      = a_out_valid && !b_in_ready && !flush;
        hold_b      = b_out_valid && !out_ready && !flush;
        prev_a_data = a_out_data;
        prev_a_tag  = a_out_tag;
        prev_b_data = b_out_data;
        prev_b_tag  = b_out_tag;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_a_valid"}, a_out_valid, 1'b0);
        check({tag, "_b_valid"}, b_out_valid, 1'b0);
        check({tag, "_b_data"}, b_out_data, '0);
        check({tag, "_b_tag"}, b_out_tag, '0);
        check({tag, "_b_keys"}, b_out_keys == '0, 1'b1);
        check({tag, "_busy"}, {a_busy, b_busy}, 2'b00);
        check({tag, "_in_ready"}, a_in_ready, 1'b1);
`ifdef AES_STAGE_PERF_CNT_EN
        check({tag, "_perf"}, {a_blk, a_stall, b_blk, b_stall}, '0);
`endif
    endtask

    task automatic reset_mid();
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_reset_state("rst_mid");
        qa.delete();
        qb.delete();
        m_a_blk = 0; m_a_stall = 0; m_b_blk = 0; m_b_stall = 0;
        hold_a = 1'b0;
        hold_b = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        d_valid  = 1'b0;
        d_flush  = 1'b0;
        d_oready = 1'b1;
        for (int i = 0; i < 40 && (qa.size() != 0 || qb.size() != 0); i++) tick();
        check("drain_a", qa.size(), 0);
        check("drain_b", qb.size(), 0);
    endtask

    initial begin
        logic [128*NK-1:0] fips_keys;
        int acc, a_first, b_first, run, max_run, exp_tag;

        build_sbox();
        fips_keys = expand(128'h000102030405060708090a0b0c0d0e0f);

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_data = '0; in_keys = '0; in_tag = '0;
        #3;
        check_reset_state("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // FIPS-197 C.1 single block: latencies and known intermediate/final states
        d_valid = 1'b1; d_data = 128'h00112233445566778899aabbccddeeff;
        d_keys = fips_keys; d_tag = 8'h5a; d_oready = 1'b1;
        tick();
        acc = cyc;
        d_valid = 1'b0;
        a_first = -1;
        b_first = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (a_out_valid && a_first < 0) begin
                a_first = cyc;
                check("fips_round2", a_out_data, 128'h4915598f55e5d7a0daca94fa1f0a63f7);
            end
            if (b_out_valid && b_first < 0) begin
                b_first = cyc;
                check("fips_ct", b_out_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
                check("fips_tag", b_out_tag, 8'h5a);
                check("fips_keys", b_out_keys == fips_keys, 1'b1);
            end
        end
        check("lat_a", 128'(a_first - acc), 128'(2));
        check("lat_b", 128'(b_first - acc), 128'(10));
        drain();

        // 16 back-to-back blocks, downstream always ready
        run = 0;
        max_run = 0;
        exp_tag = 0;
        for (int i = 0; i < 40; i++) begin
            d_valid = (i < 16);
            d_data  = rand128();
            d_keys  = rand_keys();
            d_tag   = TW'(i);
            tick();
            if (i < 16) check("bb_in_ready", a_in_ready, 1'b1);
            if (b_out_valid) begin
                run++;
                check("bb_tag_order", b_out_tag, TW'(exp_tag));
                exp_tag++;
            end else begin
                run = 0;
            end
            if (run > max_run) max_run = run;
        end
        check("bb_run", max_run, 16);
        drain();

        // Fill, then hold out_ready low for 5 cycles with input still offered
        for (int i = 0; i < 17; i++) begin
            d_valid  = 1'b1;
            d_data   = rand128();
            d_keys   = rand_keys();
            d_tag    = TW'($urandom);
            d_oready = (i < 12);
            tick();
            if (i >= 12) check("stall_in_ready", a_in_ready, 1'b0);
        end
        drain();

        // Flush with a block offered and two blocks in flight
        for (int i = 0; i < 2; i++) begin
            d_valid = 1'b1; d_data = rand128(); d_keys = rand_keys(); d_tag = TW'(i + 100);
            tick();
        end
        d_flush = 1'b1;
        d_data  = rand128();
        tick();
        check("flush_in_ready", a_in_ready, 1'b0);
        d_flush = 1'b0;
        d_valid = 1'b0;
        tick();
        check("flush_out_valid", {a_out_valid, b_out_valid}, 2'b00);
        check("flush_busy", {a_busy, b_busy}, 2'b00);

        // Randomized traffic with backpressure, occasional flush, one mid-stream reset
        for (int i = 0; i < 400; i++) begin
            if (i == 200) reset_mid();
            d_valid  = ($urandom_range(0, 3) != 0);
            d_oready = ($urandom_range(0, 9) < 7);
            d_flush  = ($urandom_range(0, 49) == 0);
            d_data   = rand128();
            d_keys   = rand_keys();
            d_tag    = TW'($urandom);
            tick();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
